// File: rtl/m_ext_pkg.sv
// Shared definitions for the M-extension divide path.
package m_ext_pkg;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    CALC,
    FIX,
    DONE
  } div_state_e;

  function automatic logic is_signed_op(input logic [2:0] f3);
    return (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, emit a quotient bit.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_out,
  output logic [XLEN-1:0] quo_out
);

  // One extra bit above the remainder keeps the trial subtraction's sign exact.
  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] diff;
  logic            ge;

  assign shifted = {rem_in, quo_in[XLEN-1]};
  assign diff    = shifted - {2'b00, divisor};
  assign ge      = ~diff[XLEN+1];
  assign rem_out = ge ? diff[XLEN:0] : shifted[XLEN:0];
  assign quo_out = {quo_in[XLEN-2:0], ge};

endmodule

// File: rtl/div_unit.sv
// Iterative DIV/DIVU/REM/REMU (+W forms at XLEN=64) with valid/ready on
// both sides, BITS_PER_CYCLE restoring steps per cycle, early-out and kill.
module div_unit
  import m_ext_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int EARLY_OUT      = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_f3,
  input  logic            i_w,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic            i_kill,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_res,
  output logic            o_busy
);

  localparam int BPC = BITS_PER_CYCLE;
  localparam int CW  = $clog2(XLEN / BPC);
  localparam logic [CW-1:0] N_FULL = CW'(XLEN / BPC - 1);
  localparam logic [CW-1:0] N_W    = CW'(32 / BPC - 1);

  div_state_e      state, state_nxt;
  logic [2:0]      f3_q;
  logic            w_q;
  logic [XLEN-1:0] a_q, b_q, quo_q, sp_res_q, res_q;
  logic [XLEN:0]   rem_q;
  logic [CW-1:0]   cnt_q;
  logic            negq_q, negr_q, sp_q;

  logic            accept, w_in, sgn_in;
  logic [XLEN-1:0] a_ext, b_ext;

  logic            sgn, is_rem, a_neg, b_neg, div0, ovf, early;
  logic [XLEN-1:0] a_mag, b_mag, min_v, sp_val, quo_init;
  logic [XLEN-1:0] q_fix, r_fix, res_fix;

  logic [BPC:0][XLEN:0]   rem_c;
  logic [BPC:0][XLEN-1:0] quo_c;

  assign accept  = (state == IDLE) & i_valid & ~i_kill;
  assign o_ready = (state == IDLE);
  assign o_busy  = (state != IDLE);
  assign o_valid = (state == DONE);
  assign o_res   = res_q;

  // Operand extension at accept: W forms take rs[31:0], sign- or zero-extended.
  always_comb begin
    w_in   = (XLEN == 64) && i_w;
    sgn_in = is_signed_op(i_f3);
    a_ext  = i_rs1;
    b_ext  = i_rs2;
    if (w_in) begin
      for (int i = 32; i < XLEN; i++) begin
        a_ext[i] = sgn_in & i_rs1[31];
        b_ext[i] = sgn_in & i_rs2[31];
      end
    end
  end

  // Operand analysis used in PREP: magnitudes, signs, special cases, early-out.
  always_comb begin
    sgn      = is_signed_op(f3_q);
    is_rem   = (f3_q == F3_REM) || (f3_q == F3_REMU);
    a_neg    = sgn & a_q[XLEN-1];
    b_neg    = sgn & b_q[XLEN-1];
    a_mag    = a_neg ? -a_q : a_q;
    b_mag    = b_neg ? -b_q : b_q;
    min_v    = w_q ? ({XLEN{1'b1}} << 31) : (XLEN'(1) << (XLEN - 1));
    div0     = (b_q == '0);
    ovf      = sgn && (a_q == min_v) && (b_q == '1);
    early    = (EARLY_OUT != 0) && (a_mag < b_mag);
    sp_val   = div0 ? (is_rem ? a_q : '1) : (is_rem ? '0 : a_q);
    // W dividends sit in the top 32 bits so the low 32 quotient bits land
    // after only 32 steps.
    quo_init = w_q ? (a_mag << (XLEN - 32)) : a_mag;
  end

  // Sign correction and result selection for FIX.
  always_comb begin
    q_fix   = negq_q ? -quo_q : quo_q;
    r_fix   = negr_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    res_fix = sp_q ? sp_res_q : (is_rem ? r_fix : q_fix);
    if (w_q) begin
      for (int i = 32; i < XLEN; i++) res_fix[i] = res_fix[31];
    end
  end

  // Chain of restoring steps, BITS_PER_CYCLE deep.
  assign rem_c[0] = rem_q;
  assign quo_c[0] = quo_q;
  for (genvar g = 0; g < BPC; g++) begin : g_step
    div_step #(.XLEN(XLEN)) u_step (
      .rem_in  (rem_c[g]),
      .quo_in  (quo_c[g]),
      .divisor (b_q),
      .rem_out (rem_c[g+1]),
      .quo_out (quo_c[g+1])
    );
  end

  // FSM next state; kill overrides everything outside IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = PREP;
      PREP:    state_nxt = (div0 | ovf | early) ? FIX : CALC;
      CALC:    if (cnt_q == '0) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    if (i_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (i_kill && (state != IDLE)) state_nxt = IDLE;
  end

  // State register and datapath registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      f3_q     <= '0;
      w_q      <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      sp_res_q <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      sp_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (accept) begin
          f3_q <= i_f3;
          w_q  <= w_in;
          a_q  <= a_ext;
          b_q  <= b_ext;
        end
        PREP: begin
          sp_q     <= div0 | ovf;
          sp_res_q <= sp_val;
          negq_q   <= a_neg ^ b_neg;
          negr_q   <= a_neg;
          b_q      <= b_mag;
          cnt_q    <= w_q ? N_W : N_FULL;
          if (early) begin
            quo_q <= '0;
            rem_q <= {1'b0, a_mag};
          end else begin
            quo_q <= quo_init;
            rem_q <= '0;
          end
        end
        CALC: begin
          rem_q <= rem_c[BPC];
          quo_q <= quo_c[BPC];
          cnt_q <= cnt_q - 1'b1;
        end
        FIX: if (!i_kill) res_q <= res_fix;
        default: ;
      endcase
    end
  end

endmodule
